// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - modulo-N up/down counter with prescaler, load/clear and cascade terminal count
module modn_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             overflow,
    output logic             load_err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [PW-1:0]    PTOP  = PW'(PRESCALE - 1);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("modn_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("modn_updown_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [PW-1:0] pcnt;
    logic          step;
    logic          at_top;
    logic          at_zero;
    logic          in_range;

    always_comb begin
        at_top   = (out == TOP);
        at_zero  = (out == '0);
        step     = en & (pcnt == PTOP);
        // Terminal count looks ahead one edge so a chained stage steps as this one wraps
        tc       = step & (up ? at_top : at_zero);
        in_range = ({1'b0, load_value} < MOD_W);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out      <= '0;
            pcnt     <= '0;
            overflow <= 1'b0;
            load_err <= 1'b0;
        end else if (clear) begin
            out      <= '0;
            pcnt     <= '0;
            overflow <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            out      <= in_range ? load_value : TOP;
            load_err <= ~in_range;
            pcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            load_err <= 1'b0;
            if (en) begin
                pcnt <= (pcnt == PTOP) ? '0 : pcnt + 1'b1;
            end
            if (step) begin
                if (up) begin
                    if (at_top) begin
                        out      <= '0;
                        overflow <= 1'b1;
                    end else begin
                        out <= out + 1'b1;
                    end
                end else begin
                    if (at_zero) begin
                        out      <= TOP;
                        overflow <= 1'b1;
                    end else begin
                        out <= out - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - randomized self-checking bench for modn_updown_counter
module tb_modn_updown_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       en    = 1'b0;
    logic       up    = 1'b1;
    logic       load  = 1'b0;
    logic [3:0] load_value = '0;
    logic       chain_en = 1'b0;

    logic [3:0] dout [4];
    logic [2:0] out3;
    logic [3:0] tcv, ovv, lev;

    logic [3:0] c0_out, c1_out;
    logic       c0_tc, c1_tc, c0_ov, c1_ov, c0_le, c1_le;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance parameters mirrored for the reference model
    int MODA [4] = '{12, 12, 16, 8};
    int PREA [4] = '{1, 3, 1, 1};
    int WA   [4] = '{4, 4, 4, 3};

    int m_out [4];
    int m_p   [4];
    int m_ov  [4];
    int m_le  [4];
    int c_total;
    int c_ov;

    always #5 clock = ~clock;

    modn_updown_counter #(.WIDTH(4), .MODULUS(12), .PRESCALE(1)) u0 (
        .clock(clock), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_value(load_value), .out(dout[0]), .tc(tcv[0]), .overflow(ovv[0]), .load_err(lev[0]));
    modn_updown_counter #(.WIDTH(4), .MODULUS(12), .PRESCALE(3)) u1 (
        .clock(clock), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_value(load_value), .out(dout[1]), .tc(tcv[1]), .overflow(ovv[1]), .load_err(lev[1]));
    modn_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u2 (
        .clock(clock), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_value(load_value), .out(dout[2]), .tc(tcv[2]), .overflow(ovv[2]), .load_err(lev[2]));
    modn_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) u3 (
        .clock(clock), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_value(load_value[2:0]), .out(out3), .tc(tcv[3]), .overflow(ovv[3]), .load_err(lev[3]));
    assign dout[3] = {1'b0, out3};

    modn_updown_counter #(.WIDTH(4), .MODULUS(12), .PRESCALE(1)) c0 (
        .clock(clock), .reset(reset), .clear(1'b0), .en(chain_en), .up(1'b1), .load(1'b0),
        .load_value(4'd0), .out(c0_out), .tc(c0_tc), .overflow(c0_ov), .load_err(c0_le));
    modn_updown_counter #(.WIDTH(4), .MODULUS(12), .PRESCALE(1)) c1 (
        .clock(clock), .reset(reset), .clear(1'b0), .en(c0_tc), .up(1'b1), .load(1'b0),
        .load_value(4'd0), .out(c1_out), .tc(c1_tc), .overflow(c1_ov), .load_err(c1_le));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 0; m_p[i] = 0; m_ov[i] = 0; m_le[i] = 0;
        end
        c_total = 0;
        c_ov    = 0;
    endtask

    // Counts as a plain integer in 0..MODULUS-1; prescaler as a modulo-PRESCALE tally
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            int lv;
            bit stp;
            lv  = int'(load_value) % (1 << WA[i]);
            stp = en && (m_p[i] == PREA[i] - 1);
            if (clear) begin
                m_out[i] = 0; m_p[i] = 0; m_ov[i] = 0; m_le[i] = 0;
            end else if (load) begin
                if (lv < MODA[i]) begin
                    m_out[i] = lv; m_le[i] = 0;
                end else begin
                    m_out[i] = MODA[i] - 1; m_le[i] = 1;
                end
                m_p[i] = 0; m_ov[i] = 0;
            end else begin
                m_ov[i] = 0; m_le[i] = 0;
                if (en) m_p[i] = (m_p[i] + 1) % PREA[i];
                if (stp) begin
                    if (up) begin
                        m_ov[i]  = (m_out[i] == MODA[i] - 1);
                        m_out[i] = (m_out[i] + 1) % MODA[i];
                    end else begin
                        m_ov[i]  = (m_out[i] == 0);
                        m_out[i] = (m_out[i] + MODA[i] - 1) % MODA[i];
                    end
                end
            end
        end
        if (chain_en) begin
            c_ov    = (c_total == 143);
            c_total = (c_total + 1) % 144;
        end else begin
            c_ov = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            bit stp, term;
            stp  = en && (m_p[i] == PREA[i] - 1);
            term = up ? (m_out[i] == MODA[i] - 1) : (m_out[i] == 0);
            check($sformatf("out%0d", i), int'(dout[i]), m_out[i]);
            check($sformatf("tc%0d", i), int'(tcv[i]), int'(stp && term));
            check($sformatf("overflow%0d", i), int'(ovv[i]), m_ov[i]);
            check($sformatf("load_err%0d", i), int'(lev[i]), m_le[i]);
        end
        check("chain_count", int'(c1_out) * 12 + int'(c0_out), c_total);
        check("chain_overflow1", int'(c1_ov), c_ov);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_out%0d", i), int'(dout[i]), 0);
            check($sformatf("reset_ovf%0d", i), int'(ovv[i]), 0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 900; k++) begin
            @(negedge clock);
            if (k < 13) begin
                en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0; chain_en = 1'b1;
            end else begin
                en         = ($urandom_range(3, 0) != 0);
                if ($urandom_range(15, 0) == 0) up = ~up;
                clear      = ($urandom_range(39, 0) == 0);
                load       = ($urandom_range(11, 0) == 0);
                load_value = 4'($urandom_range(15, 0));
                chain_en   = ($urandom_range(7, 0) != 0);
            end
            #1;
            check_all();
            @(posedge clock);
            model_edge();
            if (k == 400 || k == 651) begin
                // Async reset landing between edges must clear everything at once
                #2 reset = 1'b1;
                #1;
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("async_out%0d", i), int'(dout[i]), 0);
                    check($sformatf("async_ovf%0d", i), int'(ovv[i]), 0);
                    check($sformatf("async_lerr%0d", i), int'(lev[i]), 0);
                end
                check("async_chain", int'(c1_out) * 12 + int'(c0_out), 0);
                model_reset();
                #1 reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
